bht_resolve_update: RTL and testbench

- Branch history table on the frontend side that consumes resolved-branch records from the execute-stage branch unit.
- Keeps one 2-bit saturating counter plus a valid bit per entry.
- Answers taken/not-taken lookups for the fetch PC with a 1-cycle registered latency.
- Clears itself sequentially after reset and after a flush.

---
 rtl/bht_resolve_update_pkg.sv | 25 ++
 rtl/bht_resolve_update_if.sv | 28 ++
 rtl/bht_resolve_update_sat_counter.sv | 12 +
 rtl/bht_resolve_update.sv | 75 +++++++
 tb/tb_bht_resolve_update.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/bht_resolve_update_pkg.sv
// bht_resolve_update_pkg: shared branch-history-table types and the 2-bit counter rule
package bht_resolve_update_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_e;

    typedef struct packed {
        logic     valid;
        bht_ctr_e ctr;
    } bht_entry_t;

    typedef enum logic {INIT, IDLE} bht_state_e;

    localparam bht_entry_t BHT_ENTRY_RST = '{valid: 1'b0, ctr: WNT};

    function automatic bht_ctr_e sat_update(bht_ctr_e ctr, logic taken);
        return taken ? ((ctr == ST)  ? ST  : bht_ctr_e'(ctr + 2'd1))
                     : ((ctr == SNT) ? SNT : bht_ctr_e'(ctr - 2'd1));
    endfunction

endpackage

// File: rtl/bht_resolve_update_if.sv
// bht_resolve_update_if: fetch lookup, resolved-branch update and control signals of the BHT
interface bht_resolve_update_if #(
    parameter int unsigned VLEN = 64
);
    logic            flush_i;
    logic            debug_mode_i;
    logic            lookup_valid_i;
    logic [VLEN-1:0] lookup_pc_i;
    logic            upd_valid_i;
    logic [VLEN-1:0] upd_pc_i;
    logic            upd_is_branch_i;
    logic            upd_taken_i;
    logic            pred_valid_o;
    logic            pred_taken_o;
    logic            init_busy_o;

    modport master (
        output flush_i, debug_mode_i, lookup_valid_i, lookup_pc_i,
               upd_valid_i, upd_pc_i, upd_is_branch_i, upd_taken_i,
        input  pred_valid_o, pred_taken_o, init_busy_o
    );

    modport slave (
        input  flush_i, debug_mode_i, lookup_valid_i, lookup_pc_i,
               upd_valid_i, upd_pc_i, upd_is_branch_i, upd_taken_i,
        output pred_valid_o, pred_taken_o, init_busy_o
    );
endinterface

// File: rtl/bht_resolve_update_sat_counter.sv
// bht_resolve_update_sat_counter: next entry value for a resolved conditional branch
module bht_resolve_update_sat_counter
    import bht_resolve_update_pkg::*;
(
    input  bht_entry_t cur,
    input  logic       taken,
    output bht_entry_t nxt
);
    // A first sighting seeds the weak state in the observed direction
    always_comb nxt = '{valid: 1'b1,
                        ctr: cur.valid ? sat_update(cur.ctr, taken) : (taken ? WT : WNT)};
endmodule

// File: rtl/bht_resolve_update.sv
// bht_resolve_update: untagged 2-bit BHT with registered lookup and sequential clear
module bht_resolve_update
    import bht_resolve_update_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 1024,
    parameter int unsigned VLEN       = 64,
    parameter bit          RVC        = 1'b1
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    bht_resolve_update_if.slave bus
);
    localparam int unsigned IW  = $clog2(NR_ENTRIES);
    localparam int unsigned OFF = RVC ? 1 : 2;

    bht_state_e      state;
    logic [IW-1:0]   init_idx;
    bht_entry_t      tbl [NR_ENTRIES];
    logic [IW-1:0]   lookup_idx;
    logic [IW-1:0]   upd_idx;
    bht_entry_t      upd_next;
    logic            upd_en;
    logic            pred_valid;
    logic            pred_taken;
    logic [VLEN-1:0] unused_pc_bits;

    assign lookup_idx     = bus.lookup_pc_i[OFF+IW-1:OFF];
    assign upd_idx        = bus.upd_pc_i[OFF+IW-1:OFF];
    assign unused_pc_bits = bus.lookup_pc_i ^ bus.upd_pc_i;
    assign upd_en         = state == IDLE && !bus.flush_i && bus.upd_valid_i
                            && bus.upd_is_branch_i && !bus.debug_mode_i;

    bht_resolve_update_sat_counter u_sat (
        .cur   (tbl[upd_idx]),
        .taken (bus.upd_taken_i),
        .nxt   (upd_next)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= INIT;
            init_idx   <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else if (state == INIT) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            init_idx   <= bus.flush_i ? '0 : init_idx + 1'b1;
            if (!bus.flush_i && init_idx == '1)
                state <= IDLE;
        end else if (bus.flush_i) begin
            state      <= INIT;
            init_idx   <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else begin
            pred_valid <= bus.lookup_valid_i;
            pred_taken <= bus.lookup_valid_i & tbl[lookup_idx].valid & tbl[lookup_idx].ctr[1];
        end
    end

    // Lookup reads the old entry, so a same-cycle update is read-before-write
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (state == INIT)
                tbl[init_idx] <= BHT_ENTRY_RST;
            else if (upd_en)
                tbl[upd_idx] <= upd_next;
        end
    end

    assign bus.pred_valid_o = pred_valid;
    assign bus.pred_taken_o = pred_taken;
    assign bus.init_busy_o  = state == INIT;
endmodule

// File: tb/tb_bht_resolve_update.sv
// tb_bht_resolve_update: directed and random checks of the BHT against a table model
module tb_bht_resolve_update;
    localparam int NR = 16;
    localparam int VL = 64;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    bht_resolve_update_if #(.VLEN(VL)) bus ();

    bht_resolve_update #(.NR_ENTRIES(NR), .VLEN(VL), .RVC(1'b1)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;
    bit mv [NR];
    int mc [NR];
    int init_left = NR;
    bit e_pv = 1'b0;
    bit e_pt = 1'b0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int idx(logic [63:0] pc);
        return int'((pc >> 1) % NR);
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < NR; i++) begin
            mv[i] = 1'b0;
            mc[i] = 1;
        end
    endfunction

    // Outcome of the coming clock edge, from the table rules
    function automatic void model_step();
        int li;
        int ui;
        li = idx(bus.lookup_pc_i);
        ui = idx(bus.upd_pc_i);
        if (!rst_ni) begin
            init_left = NR;
            clear_model();
            e_pv = 1'b0;
            e_pt = 1'b0;
        end else if (init_left > 0) begin
            e_pv = 1'b0;
            e_pt = 1'b0;
            init_left = bus.flush_i ? NR : init_left - 1;
        end else if (bus.flush_i) begin
            init_left = NR;
            clear_model();
            e_pv = 1'b0;
            e_pt = 1'b0;
        end else begin
            e_pv = bus.lookup_valid_i;
            e_pt = bus.lookup_valid_i && mv[li] && mc[li] >= 2;
            if (bus.upd_valid_i && bus.upd_is_branch_i && !bus.debug_mode_i) begin
                if (!mv[ui]) begin
                    mc[ui] = bus.upd_taken_i ? 2 : 1;
                    mv[ui] = 1'b1;
                end else if (bus.upd_taken_i)
                    mc[ui] = (mc[ui] == 3) ? 3 : mc[ui] + 1;
                else
                    mc[ui] = (mc[ui] == 0) ? 0 : mc[ui] - 1;
            end
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
        check("busy", bus.init_busy_o, init_left > 0);
        check("pred_valid", bus.pred_valid_o, e_pv);
        check("pred_taken", bus.pred_taken_o, e_pt);
    endtask

    task automatic quiet();
        bus.flush_i         = 1'b0;
        bus.debug_mode_i    = 1'b0;
        bus.lookup_valid_i  = 1'b0;
        bus.lookup_pc_i     = '0;
        bus.upd_valid_i     = 1'b0;
        bus.upd_pc_i        = '0;
        bus.upd_is_branch_i = 1'b0;
        bus.upd_taken_i     = 1'b0;
    endtask

    task automatic upd(logic [63:0] pc, bit br, bit tk, bit dbg);
        bus.upd_valid_i     = 1'b1;
        bus.upd_pc_i        = pc;
        bus.upd_is_branch_i = br;
        bus.upd_taken_i     = tk;
        bus.debug_mode_i    = dbg;
        tick();
        quiet();
    endtask

    task automatic look(string tag, logic [63:0] pc, bit exp_taken);
        bus.lookup_valid_i = 1'b1;
        bus.lookup_pc_i    = pc;
        tick();
        quiet();
        check({tag, "_v"}, bus.pred_valid_o, 1);
        check({tag, "_t"}, bus.pred_taken_o, exp_taken);
    endtask

    task automatic wait_init(string tag);
        int n;
        n = 0;
        while (bus.init_busy_o && n < 40) begin
            tick();
            n++;
        end
        check(tag, n, NR);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (3) tick();
        check("rst_busy", bus.init_busy_o, 1);
        rst_ni = 1'b1;
    endtask

    initial begin
        quiet();
        clear_model();
        do_reset();
        wait_init("rst_init_len");
        look("rst_look", 64'h8000_0000, 1'b0);

        repeat (3) upd(64'h1004, 1'b1, 1'b1, 1'b0);
        look("sat_taken", 64'h1004, 1'b1);
        repeat (2) upd(64'h1004, 1'b1, 1'b0, 1'b0);
        look("sat_back", 64'h1004, 1'b0);

        bus.upd_valid_i     = 1'b1;
        bus.upd_pc_i        = 64'h2000;
        bus.upd_is_branch_i = 1'b1;
        bus.upd_taken_i     = 1'b1;
        bus.lookup_valid_i  = 1'b1;
        bus.lookup_pc_i     = 64'h2000;
        tick();
        quiet();
        check("rbw_old", bus.pred_taken_o, 0);
        look("rbw_new", 64'h2000, 1'b1);

        bus.flush_i = 1'b1;
        tick();
        quiet();
        wait_init("flush_init_len");
        upd(64'h3000, 1'b0, 1'b1, 1'b0);
        upd(64'h3000, 1'b1, 1'b1, 1'b1);
        look("ignored", 64'h3000, 1'b0);

        do_reset();
        bus.upd_valid_i     = 1'b1;
        bus.upd_pc_i        = 64'h1004;
        bus.upd_is_branch_i = 1'b1;
        bus.upd_taken_i     = 1'b1;
        repeat (7) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        wait_init("midinit_len");
        quiet();
        look("init_drop", 64'h1004, 1'b0);

        upd(64'h0002, 1'b1, 1'b1, 1'b0);
        look("alias_a", 64'h0002, 1'b1);
        look("alias_b", 64'h0022, 1'b1);

        for (int i = 0; i < 800; i++) begin
            rst_ni              = $urandom_range(0, 199) != 0;
            bus.flush_i         = $urandom_range(0, 99) == 0;
            bus.debug_mode_i    = $urandom_range(0, 9) == 0;
            bus.lookup_valid_i  = 1'($urandom);
            bus.lookup_pc_i     = {32'($urandom), 32'($urandom_range(0, 63))};
            bus.upd_valid_i     = 1'($urandom);
            bus.upd_pc_i        = {32'($urandom), 32'($urandom_range(0, 63))};
            bus.upd_is_branch_i = $urandom_range(0, 3) != 0;
            bus.upd_taken_i     = 1'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
